// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the issue controller: RV32I opcodes, instruction field
// helpers, issue operation codes, FSM state encodings and the decoded-entry struct.
// Imported by issue_ctrl and issue_ctrl_decoder.
package issue_ctrl_pkg;

    localparam int OPTYPE_W = 6;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [OPTYPE_W-1:0] {
        OP_NONE = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } optype_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;     // opcode belongs to the supported RV32I set
        logic        is_ls;     // load/store, routed to the LSB
        logic        is_jump;   // JAL, JALR or conditional branch
        optype_e     optype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    // Instruction field helpers
    function automatic logic [6:0] f_opcode(input logic [31:0] i);
        return i[6:0];
    endfunction
    function automatic logic [2:0] f_funct3(input logic [31:0] i);
        return i[14:12];
    endfunction
    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[11:7];
    endfunction
    function automatic logic [4:0] f_rs1(input logic [31:0] i);
        return i[19:15];
    endfunction
    function automatic logic [4:0] f_rs2(input logic [31:0] i);
        return i[24:20];
    endfunction

endpackage

// File: rtl/issue_ctrl_decoder.sv
// Purpose: purely combinational RV32I decoder for the issue-queue head entry.
// Ports:   instr (32-bit instruction word) -> dec (decoded fields, valid=0 for
//          opcodes outside RV32I). Zero latency, no flow control.
module issue_ctrl_decoder
    import issue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [2:0] f3;
    logic       alt;    // instr[30] selects SUB/SRA/SRAI

    assign f3  = f_funct3(instr);
    assign alt = instr[30];

    always_comb begin
        dec         = '0;
        dec.rd      = f_rd(instr);
        dec.rs1     = f_rs1(instr);
        dec.rs2     = f_rs2(instr);
        dec.optype  = OP_NONE;
        case (f_opcode(instr))
            OPC_LUI, OPC_AUIPC: begin
                dec.valid  = 1'b1;
                dec.optype = (f_opcode(instr) == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.imm    = {instr[31:12], 12'b0};
                dec.rs1    = 5'd0;
                dec.rs2    = 5'd0;
            end
            OPC_JAL: begin
                dec.valid   = 1'b1;
                dec.is_jump = 1'b1;
                dec.optype  = OP_JAL;
                dec.imm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.rs1     = 5'd0;
                dec.rs2     = 5'd0;
            end
            OPC_JALR: begin
                dec.valid   = 1'b1;
                dec.is_jump = 1'b1;
                dec.optype  = OP_JALR;
                dec.imm     = {{20{instr[31]}}, instr[31:20]};
                dec.rs2     = 5'd0;
            end
            OPC_BRANCH: begin
                dec.valid   = 1'b1;
                dec.is_jump = 1'b1;
                dec.imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec.rd      = 5'd0;
                case (f3)
                    3'b000:  dec.optype = OP_BEQ;
                    3'b001:  dec.optype = OP_BNE;
                    3'b100:  dec.optype = OP_BLT;
                    3'b101:  dec.optype = OP_BGE;
                    3'b110:  dec.optype = OP_BLTU;
                    3'b111:  dec.optype = OP_BGEU;
                    default: dec.optype = OP_NONE;
                endcase
            end
            OPC_LOAD: begin
                dec.valid = 1'b1;
                dec.is_ls = 1'b1;
                dec.imm   = {{20{instr[31]}}, instr[31:20]};
                dec.rs2   = 5'd0;
                case (f3)
                    3'b000:  dec.optype = OP_LB;
                    3'b001:  dec.optype = OP_LH;
                    3'b010:  dec.optype = OP_LW;
                    3'b100:  dec.optype = OP_LBU;
                    3'b101:  dec.optype = OP_LHU;
                    default: dec.optype = OP_NONE;
                endcase
            end
            OPC_STORE: begin
                dec.valid = 1'b1;
                dec.is_ls = 1'b1;
                dec.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.rd    = 5'd0;
                case (f3)
                    3'b000:  dec.optype = OP_SB;
                    3'b001:  dec.optype = OP_SH;
                    3'b010:  dec.optype = OP_SW;
                    default: dec.optype = OP_NONE;
                endcase
            end
            OPC_OPIMM: begin
                dec.valid = 1'b1;
                dec.imm   = {{20{instr[31]}}, instr[31:20]};
                dec.rs2   = 5'd0;
                case (f3)
                    3'b000:  dec.optype = OP_ADDI;
                    3'b010:  dec.optype = OP_SLTI;
                    3'b011:  dec.optype = OP_SLTIU;
                    3'b100:  dec.optype = OP_XORI;
                    3'b110:  dec.optype = OP_ORI;
                    3'b111:  dec.optype = OP_ANDI;
                    3'b001:  dec.optype = OP_SLLI;
                    default: dec.optype = alt ? OP_SRAI : OP_SRLI;
                endcase
            end
            OPC_OP: begin
                dec.valid = 1'b1;
                case (f3)
                    3'b000:  dec.optype = alt ? OP_SUB : OP_ADD;
                    3'b001:  dec.optype = OP_SLL;
                    3'b010:  dec.optype = OP_SLT;
                    3'b011:  dec.optype = OP_SLTU;
                    3'b100:  dec.optype = OP_XOR;
                    3'b101:  dec.optype = alt ? OP_SRA : OP_SRL;
                    3'b110:  dec.optype = OP_OR;
                    default: dec.optype = OP_AND;
                endcase
            end
            default: dec.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Purpose: in-order instruction queue + issue FSM (RUN/STALL/FLUSH) feeding RS/LSB.
// Latency: accept at edge N -> iss_valid in cycle N+2; with ISSUE_BYPASS_EN an
//          accept into an empty queue that can issue shows iss_valid in N+1.
// Backpressure: if_ready drops when full or flushing; head waits on rob_full and
//          rs_full/lsb_full; rdy low freezes all state.
// Ports: fetch offer (if_*), downstream occupancy (rob/rs/lsb_full), flush,
//        registered issue bundle (iss_*), saturating stall_cnt.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                if_valid,
    input  logic [31:0]         if_instr,
    input  logic [31:0]         if_pc,
    input  logic                if_pred_jump,
    output logic                if_ready,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic                flush,
    output logic                iss_valid,
    output logic                iss_to_lsb,
    output logic                iss_is_jump,
    output logic [OPTYPE_W-1:0] iss_optype,
    output logic [4:0]          iss_rd,
    output logic [4:0]          iss_rs1,
    output logic [4:0]          iss_rs2,
    output logic [31:0]         iss_imm,
    output logic [31:0]         iss_pc,
    output logic                iss_pred_jump,
    output logic [31:0]         stall_cnt
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   q_instr [IQ_DEPTH];
    logic [31:0]   q_pc    [IQ_DEPTH];
    logic          q_pred  [IQ_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    state_e        state, state_nxt;

    logic [31:0] dec_instr;
    logic [31:0] src_pc;
    logic        src_pred;
    dec_t        dec;

    logic q_empty, live, dec_go, accept, bypass, write, pop, do_issue;

    assign q_empty = (count == '0);
    assign live    = rdy && !flush;

    // The queue keeps filling behind a blocked head; only FLUSH refuses input.
    assign if_ready = (count < CW'(IQ_DEPTH)) && (state != ST_FLUSH);

`ifdef ISSUE_BYPASS_EN
    // With an empty queue the decoder looks at the incoming word so it can
    // issue at its accept edge without touching the storage.
    assign dec_instr = q_empty ? if_instr     : q_instr[head];
    assign src_pc    = q_empty ? if_pc        : q_pc[head];
    assign src_pred  = q_empty ? if_pred_jump : q_pred[head];
    assign bypass    = accept && q_empty && (!dec.valid || dec_go);
`else
    assign dec_instr = q_instr[head];
    assign src_pc    = q_pc[head];
    assign src_pred  = q_pred[head];
    assign bypass    = 1'b0;
`endif

    issue_ctrl_decoder u_dec (
        .instr (dec_instr),
        .dec   (dec)
    );

    assign dec_go   = !rob_full && (dec.is_ls ? !lsb_full : !rs_full);
    assign accept   = live && if_valid && if_ready;
    assign write    = accept && !bypass;
    // Unsupported heads need no downstream resource, so they pop unconditionally.
    assign pop      = live && !q_empty && (!dec.valid || dec_go);
    assign do_issue = (pop || bypass) && dec.valid;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_RUN:   if (!q_empty && !pop) state_nxt = ST_STALL;
                ST_STALL: if (pop || q_empty)   state_nxt = ST_RUN;
                ST_FLUSH: state_nxt = ST_RUN;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count/pointers.
    always_ff @(posedge clk) begin
        if (write) begin
            q_instr[tail] <= if_instr;
            q_pc[tail]    <= if_pc;
            q_pred[tail]  <= if_pred_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= ST_RUN;
            stall_cnt     <= '0;
            iss_valid     <= 1'b0;
            iss_to_lsb    <= 1'b0;
            iss_is_jump   <= 1'b0;
            iss_optype    <= '0;
            iss_rd        <= '0;
            iss_rs1       <= '0;
            iss_rs2       <= '0;
            iss_imm       <= '0;
            iss_pc        <= '0;
            iss_pred_jump <= 1'b0;
        end else if (rdy) begin
            state <= state_nxt;
            if (state == ST_STALL && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                iss_valid <= 1'b0;
            end else begin
                if (write) tail <= tail + PW'(1);
                if (pop)   head <= head + PW'(1);
                count     <= count + CW'(write) - CW'(pop);
                iss_valid <= do_issue;
                if (do_issue) begin
                    iss_to_lsb    <= dec.is_ls;
                    iss_is_jump   <= dec.is_jump;
                    iss_optype    <= dec.optype;
                    iss_rd        <= dec.rd;
                    iss_rs1       <= dec.rs1;
                    iss_rs2       <= dec.rs2;
                    iss_imm       <= dec.imm;
                    iss_pc        <= src_pc;
                    iss_pred_jump <= src_pred;
                end
            end
        end else begin
            iss_valid <= 1'b0;
        end
    end

endmodule
